// File: rtl/red_seq_ctrl_if.sv
// red_seq_ctrl_if: start/busy/done handshake and operand/result bus between
// the execute stage (master) and the RED sequential controller (slave).
interface red_seq_ctrl_if;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] result;

   // Execute stage: issues requests and consumes results.
   modport master (
      output start, op_a, op_b,
      input  busy, done, result
   );

   // Controller: accepts requests and returns results.
   modport slave (
      input  start, op_a, op_b,
      output busy, done, result
   );
endinterface

// File: rtl/red_seq_ctrl.sv
// red_seq_ctrl: computes the signed nibble reduction of two 16-bit operands
// by time-sharing one 7-bit carry-lookahead adder over eight accumulate steps
// (a0, b0, a1, b1, a2, b2, a3, b3). Result is sign-extended to 16 bits.
// Optional feature macro: RED_EARLY_EXIT_EN -- finish RUN as soon as every
// nibble still to be accumulated is zero in the captured operands.

// CLA_7bit: 7-bit carry-lookahead adder, every carry is a flat sum of
// generate/propagate products rather than a ripple chain.
module CLA_7bit (
   input  logic [6:0] A,
   input  logic [6:0] B,
   input  logic       Cin,
   output logic [6:0] Sum
);
   logic [6:0] g;
   logic [6:0] p;
   logic [6:0] carry;
   logic       prod;

   assign g = A & B;
   assign p = A ^ B;

   // Lookahead carries: carry[i] = OR_j (g[j] & p[j+1..i-1]) | (Cin & p[0..i-1]).
   always_comb begin
      carry = '0;
      prod  = 1'b0;
      for (int i = 0; i < 7; i++) begin
         prod = Cin;
         for (int k = 0; k < i; k++) begin
            prod = prod & p[k];
         end
         carry[i] = prod;
         for (int j = 0; j < i; j++) begin
            prod = g[j];
            for (int k = j + 1; k < i; k++) begin
               prod = prod & p[k];
            end
            carry[i] = carry[i] | prod;
         end
      end
   end

   assign Sum = p ^ carry;
endmodule

module red_seq_ctrl (
   input logic          clk,
   input logic          rst,
   red_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [6:0]  acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] result_q, result_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Nibbles of the captured operands laid out in accumulate order.
   logic [7:0][3:0] nib_arr;
   logic [3:0]      nib_sel;
   logic [6:0]      nib_ext;
   logic [6:0]      sum;
   logic            finish_now;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nib
         assign nib_arr[2*gi]   = a_q[4*gi +: 4];
         assign nib_arr[2*gi+1] = b_q[4*gi +: 4];
      end
   endgenerate

   assign nib_sel = nib_arr[cnt_q];
   assign nib_ext = {{3{nib_sel[3]}}, nib_sel};

   // The one shared adder; the sum range never exceeds 7-bit two's complement.
   CLA_7bit u_cla (
      .A   (acc_q),
      .B   (nib_ext),
      .Cin (1'b0),
      .Sum (sum)
   );

`ifdef RED_EARLY_EXIT_EN
   // Steps at or before cnt are masked off; any remaining non-zero nibble
   // forces the run to continue.
   logic [7:0] step_done_or_zero;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_zero
         assign step_done_or_zero[gi] = (3'(gi) <= cnt_q) || (nib_arr[gi] == 4'd0);
      end
   endgenerate
   assign finish_now = (cnt_q == 3'd7) || (&step_done_or_zero);
`else
   assign finish_now = (cnt_q == 3'd7);
`endif

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // DONE accepts a new request exactly like IDLE: no bubble.
            if (bus.start) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               acc_d   = 7'd0;
               cnt_d   = 3'd0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // start is deliberately not looked at here: it is not queued.
            acc_d = sum;
            cnt_d = cnt_q + 3'd1;
            if (finish_now) begin
               result_d = {{9{sum[6]}}, sum};
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers; reset also aborts any run in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_red_seq_ctrl.sv
// tb_red_seq_ctrl: directed and randomized checks of red_seq_ctrl against a
// plain-arithmetic reference of the nibble reduction and its latency.
module tb_red_seq_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   red_seq_ctrl_if bus ();

   red_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference: sum of all eight nibbles taken as signed 4-bit integers.
   function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
      int s = 0;
      int na, nb;
      for (int i = 0; i < 4; i++) begin
         na = int'(a[4*i +: 4]);
         nb = int'(b[4*i +: 4]);
         if (na >= 8) na -= 16;
         if (nb >= 8) nb -= 16;
         s += na + nb;
      end
      return 16'(s);
   endfunction

   // Cycles from the accepting edge to done.
   function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
      int last = 0;
      logic [3:0] n;
      for (int s = 0; s < 8; s++) begin
         n = s[0] ? b[4*(s/2) +: 4] : a[4*(s/2) +: 4];
         if (n != 4'd0) last = s;
      end
`ifdef RED_EARLY_EXIT_EN
      return last + 2;
`else
      return (last >= 0) ? 9 : 9;
`endif
   endfunction

   // Issue one request in cycle 0 and watch until done (bounded).
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [15:0] res, output bit busy_ok);
      lat     = -1;
      res     = 'x;
      busy_ok = 1'b1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.op_a  = 16'($urandom);
         bus.op_b  = 16'($urandom);
         if (bus.done) begin
            lat = k;
            res = bus.result;
            if (bus.busy) busy_ok = 1'b0;
            break;
         end else if (!bus.busy) begin
            busy_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      int ndone = 0;
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      n_checks++;
      if (bus.result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", bus.result); end
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) ndone++;
      end
      n_checks++;
      if (ndone != 0) begin n_fail++; $display("FAIL idle_quiet got=%0d active cycles exp=0", ndone); end
      $display("test_reset: done");
   endtask

   task automatic test_extremes();
      logic [15:0] a_v [2] = '{16'h7777, 16'h8888};
      logic [15:0] r_v [2] = '{16'h0038, 16'hFFC0};
      int lat;
      logic [15:0] res;
      bit bok;
      for (int i = 0; i < 2; i++) begin
         run_op(a_v[i], a_v[i], lat, res, bok);
         n_checks++;
         if (res !== r_v[i]) begin n_fail++; $display("FAIL extreme_result op=%h got=%h exp=%h", a_v[i], res, r_v[i]); end
         n_checks++;
         if (lat != 9) begin n_fail++; $display("FAIL extreme_latency op=%h got=%0d exp=9", a_v[i], lat); end
         n_checks++;
         if (!bok) begin n_fail++; $display("FAIL extreme_busy op=%h busy pattern wrong", a_v[i]); end
         $display("test_extremes: op=%h result=%h latency=%0d", a_v[i], res, lat);
      end
   endtask

   // start held through RUN, second request taken in the DONE cycle.
   task automatic test_back_to_back();
      int d_at [$];
      logic [15:0] d_res [$];
      bit overlap = 1'b0;
      bit busy_bad = 1'b0;
      bit exp_busy;
      int at0, at1;
      logic [15:0] r0, r1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = 16'h1234;
      bus.op_b  = 16'hF0F0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (bus.done && bus.busy) overlap = 1'b1;
         exp_busy = (k >= 1 && k <= 8) || (k >= 10 && k <= 17);
         if (bus.busy !== exp_busy) busy_bad = 1'b1;
         if (bus.done === 1'b1) begin
            d_at.push_back(k);
            d_res.push_back(bus.result);
         end
         bus.start = (k <= 9);
         if (k >= 4) begin
            bus.op_a = 16'h8888;
            bus.op_b = 16'h8888;
         end
      end
      at0 = (d_at.size() > 0) ? d_at[0] : -1;
      at1 = (d_at.size() > 1) ? d_at[1] : -1;
      r0  = (d_res.size() > 0) ? d_res[0] : 16'hxxxx;
      r1  = (d_res.size() > 1) ? d_res[1] : 16'hxxxx;
      n_checks++;
      if (d_at.size() != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", d_at.size()); end
      n_checks++;
      if (at0 != 9) begin n_fail++; $display("FAIL b2b_first_cycle got=%0d exp=9", at0); end
      n_checks++;
      if (r0 !== 16'h0008) begin n_fail++; $display("FAIL b2b_first_result got=%h exp=0008", r0); end
      n_checks++;
      if (at1 != 18) begin n_fail++; $display("FAIL b2b_second_cycle got=%0d exp=18", at1); end
      n_checks++;
      if (r1 !== 16'hFFC0) begin n_fail++; $display("FAIL b2b_second_result got=%h exp=FFC0", r1); end
      n_checks++;
      if (busy_bad) begin n_fail++; $display("FAIL b2b_busy got=bad pattern exp=cycles 1-8,10-17"); end
      n_checks++;
      if (overlap) begin n_fail++; $display("FAIL b2b_overlap got=busy&done exp=never"); end
      $display("test_back_to_back: done cycles %0d,%0d results %h,%h", at0, at1, r0, r1);
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      int lat;
      logic [15:0] res;
      bit bok;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = 16'h7777;
      bus.op_b  = 16'h7777;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done === 1'b1) ndone++;
         if (k == 4) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
      n_checks++;
      if (bus.result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result got=%h exp=0000", bus.result); end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      n_checks++;
      if (ndone != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
      run_op(16'h0001, 16'h0001, lat, res, bok);
      n_checks++;
      if (res !== 16'h0002) begin n_fail++; $display("FAIL midrst_next_result got=%h exp=0002", res); end
      n_checks++;
      if (lat != exp_lat(16'h0001, 16'h0001)) begin
         n_fail++; $display("FAIL midrst_next_latency got=%0d exp=%0d", lat, exp_lat(16'h0001, 16'h0001));
      end
      $display("test_reset_mid: next result=%h latency=%0d", res, lat);
   endtask

   task automatic test_early_exit();
      logic [15:0] a_v [2] = '{16'h0003, 16'h0000};
      logic [15:0] b_v [2] = '{16'h0000, 16'h1000};
      logic [15:0] r_v [2] = '{16'h0003, 16'h0001};
      int lat;
      logic [15:0] res;
      bit bok;
      for (int i = 0; i < 2; i++) begin
         run_op(a_v[i], b_v[i], lat, res, bok);
         n_checks++;
         if (res !== r_v[i]) begin n_fail++; $display("FAIL early_result a=%h b=%h got=%h exp=%h", a_v[i], b_v[i], res, r_v[i]); end
         n_checks++;
         if (lat != exp_lat(a_v[i], b_v[i])) begin
            n_fail++; $display("FAIL early_latency a=%h b=%h got=%0d exp=%0d", a_v[i], b_v[i], lat, exp_lat(a_v[i], b_v[i]));
         end
         n_checks++;
         if (!bok) begin n_fail++; $display("FAIL early_busy a=%h b=%h busy pattern wrong", a_v[i], b_v[i]); end
         $display("test_early_exit: a=%h b=%h result=%h latency=%0d", a_v[i], b_v[i], res, lat);
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b, res;
      int lat;
      bit bok;
      int keep;
      for (int t = 0; t < 24; t++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         // Half the time clear the trailing steps to exercise short runs.
         if ($urandom_range(0, 1) == 1) begin
            keep = $urandom_range(0, 7);
            for (int s = 0; s < 8; s++) begin
               if (s > keep) begin
                  if (s % 2 == 0) a[4*(s/2) +: 4] = 4'd0;
                  else            b[4*(s/2) +: 4] = 4'd0;
               end
            end
         end
         run_op(a, b, lat, res, bok);
         n_checks++;
         if (res !== ref_red(a, b)) begin n_fail++; $display("FAIL rand_result a=%h b=%h got=%h exp=%h", a, b, res, ref_red(a, b)); end
         n_checks++;
         if (lat != exp_lat(a, b)) begin n_fail++; $display("FAIL rand_latency a=%h b=%h got=%0d exp=%0d", a, b, lat, exp_lat(a, b)); end
         n_checks++;
         if (!bok) begin n_fail++; $display("FAIL rand_busy a=%h b=%h busy pattern wrong", a, b); end
         $display("test_random: a=%h b=%h result=%h latency=%0d", a, b, res, lat);
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      test_reset();
      test_extremes();
      test_back_to_back();
      test_reset_mid();
      test_early_exit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/red_seq_ctrl.md
# red_seq_ctrl

Multi-cycle controller that computes the RED (nibble reduction) result of two 16-bit operands. It time-shares a single 7-bit carry-lookahead adder (`CLA_7bit`) over eight accumulate steps. It sits beside the ALU and is driven by the execute stage through a start/busy/done handshake. It trades latency for area: one 7-bit adder in place of a reduction tree.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when the FSM is in IDLE or DONE
- `op_a`  in  16  operand A; captured on the accepting edge
- `op_b`  in  16  operand B; captured on the accepting edge
- `busy`  out  1  high while the FSM is in RUN
- `done`  out  1  one-cycle pulse; `result` is valid while it is high
- `result`  out  16  sign-extended 7-bit reduction sum; holds until the next completion

## Operation
- Function: result = sext16( Σ sext7(op_a nibble i) + Σ sext7(op_b nibble i) ), i = 0..3, each nibble treated as signed 4-bit.
- Sum range is −64..+56, so the value always fits 7-bit two's complement.
- Adder wrap: 7-bit wrap, `Cin` = 0, `Cout` ignored. No overflow is possible.
- Datapath:
  - 7-bit accumulator `acc`, captured operand registers, 3-bit step counter `cnt`.
  - Exactly one adder instance.
  - Adder inputs are `acc` and sext7(selected nibble).
- Step order:
  - cnt = 2i selects op_a nibble i.
  - cnt = 2i+1 selects op_b nibble i.
  - Order is a0, b0, a1, b1, a2, b2, a3, b3.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on `start`, latch operands, `acc`←0, `cnt`←0, go to RUN. Otherwise stay.
  - RUN: each edge, `acc`←adder sum and `cnt`←`cnt`+1.
    - At `cnt` = 7, load `result`←sext16(adder sum) and go to DONE.
  - DONE: `done` = 1 for exactly this cycle.
    - If `start` is high, accept it exactly as from IDLE (back-to-back, no bubble).
    - Otherwise go to IDLE.
- `start` during RUN is ignored; it is not queued.
- Operand changes after acceptance have no effect.
- Reset (any state, including mid-RUN) returns to IDLE with `acc`=0 and `cnt`=0.
  - The aborted operation produces no `done`.
- Reset values: `busy`=0, `done`=0, `result`=16'h0000.

## Timing
- `start` high in cycle 0 with FSM in IDLE:
  - `busy` high in cycles 1–8.
  - `done` high and `result` valid in cycle 9; `busy` low in cycle 9.
- Fixed latency is 9 cycles from the accepting edge to `done` (default build).
- Back-to-back: `start` in cycle 9 (DONE) gives `busy` in cycles 10–17 and `done` in cycle 18.
- Throughput is one result per 9 cycles.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro: `RED_EARLY_EXIT_EN`.
- Defined:
  - In RUN, if every nibble not yet accumulated (steps `cnt`+1..7) is zero in the captured operands, the current edge loads `result` and goes to DONE.
  - RUN length is 1–8 cycles; `done` arrives 2–9 cycles after acceptance.
  - Result values are identical to the default build.
- Undefined: RUN is always exactly 8 cycles. No zero-detect logic is present.

## Test plan
- Reset: assert `rst` 2 cycles → `busy`=0, `done`=0, `result`=16'h0000. Hold `start`=0 for 5 cycles → no `done`.
- Extremes:
  - `op_a`=`op_b`=16'h7777 → `result`=16'h0038, `done` in cycle 9.
  - `op_a`=`op_b`=16'h8888 → `result`=16'hFFC0.
- Mixed sign and ignored start:
  - `op_a`=16'h1234, `op_b`=16'hF0F0 → `result`=16'h0008.
  - Hold `start` high through RUN → exactly one `done`.
  - Next operation accepted in the DONE cycle → second `done` in cycle 18.
- Reset mid-operation:
  - Start with 16'h7777/16'h7777, assert `rst` in cycle 4 → `busy`=0 in cycle 5, no `done`, `result`=16'h0000.
  - Next op 16'h0001/16'h0001 → `result`=16'h0002.
- Early exit, `op_a`=16'h0003, `op_b`=16'h0000:
  - With `RED_EARLY_EXIT_EN`: `done` in cycle 2, `result`=16'h0003.
  - Without it: `done` in cycle 9, same result.
  - `op_a`=16'h0000, `op_b`=16'h1000 → `done` in cycle 9 in both builds, `result`=16'h0001.
